// File: rtl/seg7_scan_ctrl.sv
// Time-multiplexed driver for one shared seven-segment decoder across DIGITS digits.
// Optional leading-zero blanking is enabled by defining SEG7_LZ_BLANK_EN.
`timescale 1ns/1ps
module seg7_scan_ctrl #(
  parameter int DIGITS    = 4,
  parameter int SCAN_DIV  = 1000,
  parameter int BLANK_CYC = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  upd_valid,
  input  logic [4*DIGITS-1:0]   upd_data,
  output logic                  upd_ready,
  output logic [3:0]            bcd,
  output logic [DIGITS-1:0]     an_n,
  output logic                  frame_done
);

  localparam int IW     = $clog2(DIGITS);
  localparam int CNTMAX = (SCAN_DIV > BLANK_CYC) ? SCAN_DIV : BLANK_CYC;
  localparam int CW     = $clog2(CNTMAX + 1);

  localparam logic [CW-1:0] SHOW_LAST  = CW'(SCAN_DIV - 1);
  localparam logic [CW-1:0] BLANK_LAST = CW'(BLANK_CYC - 1);
  localparam logic [IW-1:0] IDX_LAST   = IW'(DIGITS - 1);

  typedef enum logic [0:0] {
    ST_SHOW  = 1'b0,
    ST_BLANK = 1'b1
  } state_t;

  state_t              state_r, state_s;
  logic [IW-1:0]       idx_r, idx_s;
  logic [CW-1:0]       cnt_r, cnt_s;
  logic [4*DIGITS-1:0] disp_r, disp_s;
  logic [4*DIGITS-1:0] pend_r, pend_s;
  logic                pend_vld_r, pend_vld_s;
  logic                boundary_s;
  logic                take_s;
  logic                nz_s;
  logic [DIGITS-1:0]   lit_s;
  logic [DIGITS-1:0]   an_n_s;
  logic [3:0]          bcd_s;

  // Slot sequencing: SHOW for SCAN_DIV cycles, BLANK for BLANK_CYC, then next digit.
  always_comb begin
    state_s    = state_r;
    idx_s      = idx_r;
    cnt_s      = cnt_r + CW'(1);
    boundary_s = 1'b0;
    case (state_r)
      ST_SHOW: begin
        if (cnt_r == SHOW_LAST) begin
          state_s = ST_BLANK;
          cnt_s   = '0;
        end else begin
          state_s = ST_SHOW;
        end
      end
      ST_BLANK: begin
        if (cnt_r == BLANK_LAST) begin
          state_s = ST_SHOW;
          cnt_s   = '0;
          if (idx_r == IDX_LAST) begin
            idx_s      = '0;
            boundary_s = 1'b1;
          end else begin
            idx_s = idx_r + IW'(1);
          end
        end else begin
          state_s = ST_BLANK;
        end
      end
      default: begin
        state_s = ST_BLANK;
        cnt_s   = '0;
        idx_s   = IDX_LAST;
      end
    endcase
  end

  // Pending-value handshake; the display only changes when a frame begins.
  always_comb begin
    take_s     = upd_valid & upd_ready;
    disp_s     = disp_r;
    pend_s     = pend_r;
    pend_vld_s = pend_vld_r;
    if (boundary_s && pend_vld_r) begin
      disp_s     = pend_r;
      pend_vld_s = 1'b0;
    end else begin
      disp_s     = disp_r;
    end
    // A value taken on the boundary edge itself waits for the following frame.
    if (take_s) begin
      pend_s     = upd_data;
      pend_vld_s = 1'b1;
    end else begin
      pend_s     = pend_r;
    end
  end

  // Which digits may light; digit 0 is always lit.
  always_comb begin
    nz_s  = 1'b0;
    lit_s = '1;
`ifdef SEG7_LZ_BLANK_EN
    for (int i = DIGITS - 1; i >= 0; i--) begin
      nz_s     = nz_s | (disp_s[4*i +: 4] != 4'd0);
      lit_s[i] = nz_s | (i == 0);
    end
`else
    lit_s = '1;
`endif
  end

  // Next output values, aligned with the next state so outputs can be registered.
  always_comb begin
    an_n_s = '1;
    bcd_s  = bcd;
    for (int i = 0; i < DIGITS; i++) begin
      an_n_s[i] = ~((state_s == ST_SHOW) && (idx_s == IW'(i)) && lit_s[i]);
    end
    if (state_s == ST_SHOW) begin
      bcd_s = disp_s[{idx_s, 2'b00} +: 4];
    end else begin
      bcd_s = bcd;
    end
  end

  // State and output registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r    <= ST_BLANK;
      idx_r      <= IDX_LAST;
      cnt_r      <= '0;
      disp_r     <= '0;
      pend_r     <= '0;
      pend_vld_r <= 1'b0;
      upd_ready  <= 1'b0;
      an_n       <= '1;
      bcd        <= 4'd0;
      frame_done <= 1'b0;
    end else begin
      state_r    <= state_s;
      idx_r      <= idx_s;
      cnt_r      <= cnt_s;
      disp_r     <= disp_s;
      pend_r     <= pend_s;
      pend_vld_r <= pend_vld_s;
      upd_ready  <= ~pend_vld_s;
      an_n       <= an_n_s;
      bcd        <= bcd_s;
      frame_done <= boundary_s;
    end
  end

endmodule
